aq_jpeg_rgb2ycbcr: RTL and testbench

Colour-conversion front end of the JPEG encoder; inverse of the decoder's YCbCr->RGB stage. On a start request it reads one 8x8 RGB pixel tile from the encoder's tile buffer in raster order. It converts each pixel to level-shifted YCbCr 4:4:4 in Q14 fixed point and streams the three samples with in-block address and block coordinates to the forward-DCT block buffer. The whole pipeline advances only while the downstream OutReady is high.

---
 rtl/aq_jpeg_rgb2ycbcr_if.sv | 35 +++
 rtl/aq_jpeg_rgb2ycbcr.sv | 168 ++++++++++++++++
 tb/tb_aq_jpeg_rgb2ycbcr.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq_jpeg_rgb2ycbcr_if.sv
// Tile-buffer read side, start control and DCT-buffer sample stream of the RGB->YCbCr converter.
// The slave modport is the converter; the master modport is the encoder/buffer side.
interface aq_jpeg_rgb2ycbcr_if;
    logic               InEnable;
    logic [11:0]        InBlockX;
    logic [11:0]        InBlockY;
    logic               InBusy;
    logic               InRead;
    logic [5:0]         InAddress;
    logic               InReadNext;
    logic [7:0]         InR;
    logic [7:0]         InG;
    logic [7:0]         InB;
    logic               OutReady;
    logic               OutEnable;
    logic [11:0]        OutBlockX;
    logic [11:0]        OutBlockY;
    logic [5:0]         OutAddress;
    logic               OutLast;
    logic signed [8:0]  OutY;
    logic signed [8:0]  OutCb;
    logic signed [8:0]  OutCr;

    modport slave (
        input  InEnable, InBlockX, InBlockY, InR, InG, InB, OutReady,
        output InBusy, InRead, InAddress, InReadNext,
        output OutEnable, OutBlockX, OutBlockY, OutAddress, OutLast, OutY, OutCb, OutCr
    );

    modport master (
        output InEnable, InBlockX, InBlockY, InR, InG, InB, OutReady,
        input  InBusy, InRead, InAddress, InReadNext,
        input  OutEnable, OutBlockX, OutBlockY, OutAddress, OutLast, OutY, OutCb, OutCr
    );
endinterface

// File: rtl/aq_jpeg_rgb2ycbcr.sv
// Reads one 8x8 RGB tile in raster order and streams level-shifted YCbCr 4:4:4 (Q14) samples.
// Five-stage pipeline; OutReady low freezes every register, reads and outputs included.
module aq_jpeg_rgb2ycbcr #(
    parameter logic LEVEL_SHIFT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    aq_jpeg_rgb2ycbcr_if.slave bus
);
    localparam int W = 26;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    typedef struct packed {
        logic        vld;
        logic [11:0] bx;
        logic [11:0] by;
        logic [5:0]  addr;
    } tag_t;

    localparam logic signed [W-1:0] C_YR  =  26'sd4899;
    localparam logic signed [W-1:0] C_YG  =  26'sd9617;
    localparam logic signed [W-1:0] C_YB  =  26'sd1868;
    localparam logic signed [W-1:0] C_UR  = -26'sd2765;
    localparam logic signed [W-1:0] C_UG  = -26'sd5427;
    localparam logic signed [W-1:0] C_UB  =  26'sd8192;
    localparam logic signed [W-1:0] C_VR  =  26'sd8192;
    localparam logic signed [W-1:0] C_VG  = -26'sd6860;
    localparam logic signed [W-1:0] C_VB  = -26'sd1332;
    localparam logic signed [W-1:0] RND   =  26'sd8192;
    localparam logic signed [W-1:0] LS    =  26'sd128;
    localparam logic signed [W-1:0] S_MIN = -26'sd128;
    localparam logic signed [W-1:0] S_MAX =  26'sd127;
    localparam logic signed [W-1:0] U_MIN =  26'sd0;
    localparam logic signed [W-1:0] U_MAX =  26'sd255;

    function automatic logic signed [8:0] sat(input logic signed [W-1:0] v,
                                              input logic signed [W-1:0] lo,
                                              input logic signed [W-1:0] hi);
        logic signed [W-1:0] c;
        c = (v < lo) ? lo : ((v > hi) ? hi : v);
        return c[8:0];
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [11:0] bx_q, bx_d, by_q, by_d;
    logic        rd, rd_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bx_d    = bx_q;
        by_d    = by_q;
        rd      = 1'b0;
        rd_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.InEnable) begin
                    state_d = ST_RUN;
                    cnt_d   = 6'd0;
                    bx_d    = bus.InBlockX;
                    by_d    = bus.InBlockY;
                end
            end
            ST_RUN: begin
                if (bus.OutReady) begin
                    rd    = 1'b1;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        rd_last = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bx_q    <= '0;
            by_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
        end
    end

    assign bus.InBusy     = (state_q == ST_RUN);
    assign bus.InRead     = rd;
    assign bus.InAddress  = cnt_q;
    assign bus.InReadNext = rd_last;

    // tag_q[0..4] carries address/coordinates alongside S0..S4 so tiles never mix.
    tag_t                tag_q [5];
    logic signed [8:0]   r_q, g_q, b_q;
    logic signed [W-1:0] p_q [9];
    logic signed [W-1:0] p_d [9];
    logic signed [W-1:0] ysum_q, usum_q, vsum_q;
    logic signed [8:0]   y_q, u_q, v_q;
    logic signed [W-1:0] r_ext, g_ext, b_ext;
    logic signed [W-1:0] y_sh, u_sh, v_sh;
    logic signed [8:0]   y_d, u_d, v_d;

    always_comb begin
        r_ext  = W'(r_q);
        g_ext  = W'(g_q);
        b_ext  = W'(b_q);
        p_d[0] = r_ext * C_YR;
        p_d[1] = g_ext * C_YG;
        p_d[2] = b_ext * C_YB;
        p_d[3] = r_ext * C_UR;
        p_d[4] = g_ext * C_UG;
        p_d[5] = b_ext * C_UB;
        p_d[6] = r_ext * C_VR;
        p_d[7] = g_ext * C_VG;
        p_d[8] = b_ext * C_VB;
        y_sh   = ysum_q >>> 14;
        u_sh   = usum_q >>> 14;
        v_sh   = vsum_q >>> 14;
        y_d    = LEVEL_SHIFT ? sat(y_sh - LS, S_MIN, S_MAX) : sat(y_sh, U_MIN, U_MAX);
        u_d    = sat(u_sh, S_MIN, S_MAX);
        v_d    = sat(v_sh, S_MIN, S_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) tag_q[i] <= '0;
            for (int i = 0; i < 9; i++) p_q[i] <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            ysum_q <= '0;
            usum_q <= '0;
            vsum_q <= '0;
            y_q    <= '0;
            u_q    <= '0;
            v_q    <= '0;
        end else if (bus.OutReady) begin
            tag_q[0] <= '{vld: rd, bx: bx_q, by: by_q, addr: cnt_q};
            for (int i = 1; i < 5; i++) tag_q[i] <= tag_q[i-1];
            r_q    <= {1'b0, bus.InR};
            g_q    <= {1'b0, bus.InG};
            b_q    <= {1'b0, bus.InB};
            for (int i = 0; i < 9; i++) p_q[i] <= p_d[i];
            ysum_q <= p_q[0] + p_q[1] + p_q[2] + RND;
            usum_q <= p_q[3] + p_q[4] + p_q[5] + RND;
            vsum_q <= p_q[6] + p_q[7] + p_q[8] + RND;
            y_q    <= y_d;
            u_q    <= u_d;
            v_q    <= v_d;
        end
    end

    assign bus.OutEnable  = tag_q[4].vld;
    assign bus.OutBlockX  = tag_q[4].bx;
    assign bus.OutBlockY  = tag_q[4].by;
    assign bus.OutAddress = tag_q[4].addr;
    assign bus.OutLast    = tag_q[4].vld && (tag_q[4].addr == 6'd63);
    assign bus.OutY       = y_q;
    assign bus.OutCb      = u_q;
    assign bus.OutCr      = v_q;
endmodule

// File: tb/tb_aq_jpeg_rgb2ycbcr.sv
// Directed bench for aq_jpeg_rgb2ycbcr: two instances (level-shifted and raw Y) run in lockstep
// from one registered tile-buffer model; accepted samples are collected at the negative edge.
module tb_aq_jpeg_rgb2ycbcr;
    typedef struct packed {
        logic              vld;
        logic [11:0]       bx;
        logic [11:0]       by;
        logic [5:0]        addr;
        logic              last;
        logic signed [8:0] y;
        logic signed [8:0] cb;
        logic signed [8:0] cr;
    } samp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mr [64];
    logic [7:0] mg [64];
    logic [7:0] mb [64];
    samp_t      qa [$];
    samp_t      qb [$];

    int ey  [5] = '{-52, 22, -99, 127, -128};
    int ecb [5] = '{-43, -84, 127, 0, 0};
    int ecr [5] = '{127, -107, -21, 0, 0};

    aq_jpeg_rgb2ycbcr_if ifa ();
    aq_jpeg_rgb2ycbcr_if ifb ();

    aq_jpeg_rgb2ycbcr #(.LEVEL_SHIFT(1'b1)) dut_ls  (.clk(clk), .rst(rst), .bus(ifa.slave));
    aq_jpeg_rgb2ycbcr #(.LEVEL_SHIFT(1'b0)) dut_raw (.clk(clk), .rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    assign ifb.InEnable = ifa.InEnable;
    assign ifb.InBlockX = ifa.InBlockX;
    assign ifb.InBlockY = ifa.InBlockY;
    assign ifb.InR      = ifa.InR;
    assign ifb.InG      = ifa.InG;
    assign ifb.InB      = ifa.InB;
    assign ifb.OutReady = ifa.OutReady;

    // Tile buffer: data for a read appears the cycle after InRead and holds otherwise.
    always @(posedge clk) begin
        if (!rst) begin
            ifa.InR <= 8'd0;
            ifa.InG <= 8'd0;
            ifa.InB <= 8'd0;
        end else if (ifa.InRead) begin
            ifa.InR <= mr[ifa.InAddress];
            ifa.InG <= mg[ifa.InAddress];
            ifa.InB <= mb[ifa.InAddress];
        end
    end

    function automatic samp_t grab_a();
        return '{vld: ifa.OutEnable, bx: ifa.OutBlockX, by: ifa.OutBlockY, addr: ifa.OutAddress,
                 last: ifa.OutLast, y: ifa.OutY, cb: ifa.OutCb, cr: ifa.OutCr};
    endfunction

    function automatic samp_t grab_b();
        return '{vld: ifb.OutEnable, bx: ifb.OutBlockX, by: ifb.OutBlockY, addr: ifb.OutAddress,
                 last: ifb.OutLast, y: ifb.OutY, cb: ifb.OutCb, cr: ifb.OutCr};
    endfunction

    always @(negedge clk) begin
        if (ifa.OutEnable && ifa.OutReady) qa.push_back(grab_a());
        if (ifb.OutEnable && ifb.OutReady) qb.push_back(grab_b());
    end

    function automatic samp_t mk(input int bx, input int by, input int addr,
                                 input int y, input int cb, input int cr);
        return '{vld: 1'b1, bx: 12'(bx), by: 12'(by), addr: 6'(addr), last: (addr == 63),
                 y: 9'(y), cb: 9'(cb), cr: 9'(cr)};
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic samp_t model(input int bx, input int by, input int addr);
        int r, g, b, y, cb, cr;
        r  = int'(mr[addr]);
        g  = int'(mg[addr]);
        b  = int'(mb[addr]);
        y  = (4899 * r + 9617 * g + 1868 * b + 8192) >>> 14;
        cb = (-2765 * r - 5427 * g + 8192 * b + 8192) >>> 14;
        cr = (8192 * r - 6860 * g - 1332 * b + 8192) >>> 14;
        return mk(bx, by, addr, clampi(y - 128, -128, 127), clampi(cb, -128, 127), clampi(cr, -128, 127));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input samp_t obs, input samp_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %p expected %p", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        while (ifa.InBusy && k < lim) begin
            step();
            k++;
        end
        chk(tag, ifa.InBusy, 0);
    endtask

    task automatic run_tile(input int bx, input int by);
        qa.delete();
        qb.delete();
        ifa.InEnable = 1'b1;
        ifa.InBlockX = 12'(bx);
        ifa.InBlockY = 12'(by);
        step();
        ifa.InEnable = 1'b0;
        wait_idle("run_tile_idle", 500);
        repeat (8) step();
    endtask

    task automatic set_prim();
        for (int i = 0; i < 64; i++) begin
            mr[i] = 8'd200; mg[i] = 8'd200; mb[i] = 8'd200;
        end
        mr[0] = 8'd255; mg[0] = 8'd0;   mb[0] = 8'd0;
        mr[1] = 8'd0;   mg[1] = 8'd255; mb[1] = 8'd0;
        mr[2] = 8'd0;   mg[2] = 8'd0;   mb[2] = 8'd255;
        mr[3] = 8'd255; mg[3] = 8'd255; mb[3] = 8'd255;
        mr[4] = 8'd0;   mg[4] = 8'd0;   mb[4] = 8'd0;
    endtask

    task automatic check_prim(input string tag, input int bx, input int by);
        chk({tag, "_count"}, qa.size(), 64);
        for (int i = 0; i < 5 && i < qa.size(); i++)
            chk_s($sformatf("%s[%0d]", tag, i), qa[i], mk(bx, by, i, ey[i], ecb[i], ecr[i]));
    endtask

    initial begin
        int    first_rd, first_oe, nxt, starts, k;
        int    st [$];
        logic  prev_rdy, prev_busy;
        samp_t prev_out;

        // Reset state
        rst          = 1'b0;
        ifa.InEnable = 1'b0;
        ifa.InBlockX = 12'd0;
        ifa.InBlockY = 12'd0;
        ifa.OutReady = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mr[i] = 8'd200; mg[i] = 8'd200; mb[i] = 8'd200;
        end
        repeat (3) step();
        chk("rst_OutEnable", ifa.OutEnable, 0);
        chk("rst_OutY", ifa.OutY, 0);
        chk("rst_OutCb", ifa.OutCb, 0);
        chk("rst_OutCr", ifa.OutCr, 0);
        chk("rst_InBusy", ifa.InBusy, 0);
        chk("rst_InRead", ifa.InRead, 0);
        chk("rst_OutAddress", ifa.OutAddress, 0);
        rst = 1'b1;
        step();

        // Gray tile: latency, ordering, OutLast, InReadNext
        qa.delete();
        first_rd = -1; first_oe = -1; nxt = 0;
        ifa.InEnable = 1'b1;
        ifa.InBlockX = 12'd1;
        ifa.InBlockY = 12'd2;
        for (int c = 0; c < 100; c++) begin
            step();
            ifa.InEnable = 1'b0;
            if (first_rd < 0 && ifa.InRead) first_rd = c;
            if (first_oe < 0 && ifa.OutEnable) first_oe = c;
            if (ifa.InReadNext) begin
                nxt++;
                chk("gray_next_addr", ifa.InAddress, 63);
            end
        end
        chk("gray_latency", first_oe - first_rd, 5);
        chk("gray_readnext_count", nxt, 1);
        chk("gray_count", qa.size(), 64);
        for (int i = 0; i < 64 && i < qa.size(); i++)
            chk_s($sformatf("gray[%0d]", i), qa[i], mk(1, 2, i, 72, 0, 0));

        // Primaries and extremes, with the unshifted-Y instance alongside
        set_prim();
        run_tile(7, 9);
        check_prim("prim", 7, 9);
        chk("raw_count", qb.size(), 64);
        if (qb.size() >= 5) begin
            chk("raw_red_y", qb[0].y, 76);
            chk("raw_white_y", qb[3].y, 255);
            chk("raw_black_y", qb[4].y, 0);
            chk("raw_blue_cb", qb[2].cb, 127);
        end

        // Random OutReady over two back-to-back tiles (3,5) then (4,5)
        for (int i = 0; i < 64; i++) begin
            mr[i] = 8'(i * 4);
            mg[i] = 8'(255 - i * 4);
            mb[i] = 8'(i * 37);
        end
        qa.delete();
        starts = 0;
        prev_busy = 1'b0;
        prev_rdy  = 1'b1;
        prev_out  = grab_a();
        ifa.InEnable = 1'b1;
        ifa.InBlockX = 12'd3;
        ifa.InBlockY = 12'd5;
        ifa.OutReady = 1'($urandom_range(0, 1));
        prev_rdy = ifa.OutReady;
        k = 0;
        while (k < 4000 && qa.size() < 128) begin
            step();
            k++;
            if (!prev_rdy) chk_s("stall_hold", grab_a(), prev_out);
            if (ifa.InBusy && !prev_busy) starts++;
            if (starts == 1) ifa.InBlockX = 12'd4;
            if (starts >= 2) ifa.InEnable = 1'b0;
            prev_busy = ifa.InBusy;
            prev_out  = grab_a();
            ifa.OutReady = 1'($urandom_range(0, 1));
            prev_rdy = ifa.OutReady;
        end
        ifa.OutReady = 1'b1;
        ifa.InEnable = 1'b0;
        wait_idle("stall_idle", 200);
        repeat (8) step();
        chk("stall_count", qa.size(), 128);
        for (int i = 0; i < 128 && i < qa.size(); i++)
            chk_s($sformatf("stall[%0d]", i), qa[i], model(3 + i / 64, 5, i % 64));

        // InEnable held high: tiles every 65 cycles, InReadNext at address 63
        nxt = 0;
        st.delete();
        ifa.InEnable = 1'b1;
        ifa.InBlockX = 12'd8;
        ifa.InBlockY = 12'd8;
        for (int c = 0; c < 400 && st.size() < 3; c++) begin
            step();
            if (ifa.InRead && ifa.InAddress == 6'd0) st.push_back(c);
            if (ifa.InReadNext) begin
                nxt++;
                chk("hold_next_addr", ifa.InAddress, 63);
            end
        end
        ifa.InEnable = 1'b0;
        chk("hold_starts", st.size(), 3);
        if (st.size() == 3) begin
            chk("hold_gap0", st[1] - st[0], 65);
            chk("hold_gap1", st[2] - st[1], 65);
        end
        chk("hold_readnext_count", nxt, 2);
        wait_idle("hold_idle", 200);
        repeat (8) step();

        // Reset in the middle of a tile, then a clean tile
        set_prim();
        ifa.InEnable = 1'b1;
        ifa.InBlockX = 12'd2;
        ifa.InBlockY = 12'd3;
        step();
        ifa.InEnable = 1'b0;
        k = 0;
        while (!(ifa.InRead && ifa.InAddress == 6'd30) && k < 200) begin
            step();
            k++;
        end
        chk("mid_reached_30", ifa.InAddress, 30);
        rst = 1'b0;
        step();
        chk("mid_OutEnable", ifa.OutEnable, 0);
        chk("mid_OutY", ifa.OutY, 0);
        chk("mid_OutCb", ifa.OutCb, 0);
        chk("mid_OutCr", ifa.OutCr, 0);
        chk("mid_OutBlockX", ifa.OutBlockX, 0);
        chk("mid_OutAddress", ifa.OutAddress, 0);
        chk("mid_OutLast", ifa.OutLast, 0);
        chk("mid_InBusy", ifa.InBusy, 0);
        rst = 1'b1;
        qa.delete();
        repeat (20) step();
        chk("mid_no_residue", qa.size(), 0);
        run_tile(6, 6);
        check_prim("after_rst", 6, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
